// File: rtl/rvmyth_dac_sample_sched_if.sv
// Sample-source handshake and avsddac pin bundle shared by the scheduler and its neighbours.
// The master side drives samples and divider config; the slave side is the scheduler.
interface rvmyth_dac_sample_sched_if #(
    parameter int WIDTH = 10,
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] div_cfg;
    logic             div_load;

    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    logic [WIDTH-1:0] dac_d;
    logic             dac_en;
    logic             dac_update;
    logic             grant_id;
    logic             underrun;
    logic [7:0]       underrun_cnt;

    modport master (
        output div_cfg, div_load,
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        input  dac_d, dac_en, dac_update, grant_id, underrun, underrun_cnt
    );

    modport slave (
        input  div_cfg, div_load,
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        output dac_d, dac_en, dac_update, grant_id, underrun, underrun_cnt
    );
endinterface

// File: rtl/rvmyth_dac_sample_sched.sv
// Shares the avsddac D inputs between the RVMyth core and a test source, taking one
// sample per divider tick with round-robin arbitration and a held, registered code.
module rvmyth_dac_sample_sched #(
    parameter int WIDTH       = 10,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    rvmyth_dac_sample_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    state_t           state;
    state_t           state_nxt;

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt;
    logic             tick;

    logic             rr_ptr;
    logic             any_valid;
    logic             gsel;
    logic             transfer;
    logic             empty_tick;

    logic [WIDTH-1:0] dac_d_q;
    logic             grant_id_q;
    logic             dac_update_q;
    logic             underrun_q;
    logic [7:0]       underrun_cnt_q;

    logic             dac_en_c;
    logic             count_underrun;

    // A load takes priority over a pending tick so the new period starts cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= DIV_RST;
            cnt     <= DIV_RST;
        end else if (bus.div_load) begin
            div_reg <= bus.div_cfg;
            cnt     <= bus.div_cfg;
        end else if (cnt == '0) begin
            cnt     <= div_reg;
        end else begin
            cnt     <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0) && !bus.div_load;

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        gsel      = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gsel = rr_ptr;
        end else if (bus.req1_valid) begin
            gsel = 1'b1;
        end
    end

    assign transfer       = tick & any_valid;
    assign empty_tick     = tick & ~any_valid;
    assign bus.req0_ready = transfer & ~gsel;
    assign bus.req1_ready = transfer &  gsel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dac_d_q      <= '0;
            grant_id_q   <= 1'b0;
            dac_update_q <= 1'b0;
            rr_ptr       <= 1'b0;
        end else begin
            dac_update_q <= transfer;
            if (transfer) begin
                dac_d_q    <= gsel ? bus.req1_data : bus.req0_data;
                grant_id_q <= gsel;
                rr_ptr     <= ~gsel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            underrun_q <= count_underrun;
            if (count_underrun && (underrun_cnt_q != 8'hFF)) begin
                underrun_cnt_q <= underrun_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (transfer)   state_nxt = RUN;
            RUN:     if (empty_tick) state_nxt = STARVED;
            STARVED: if (transfer)   state_nxt = RUN;
            default:                 state_nxt = OFF;
        endcase
    end

    // Empty ticks before the first sample ever arrives are not counted as starvation.
    always_comb begin
        dac_en_c       = 1'b0;
        count_underrun = 1'b0;
        case (state)
            OFF: begin
                dac_en_c       = 1'b0;
                count_underrun = 1'b0;
            end
            RUN, STARVED: begin
                dac_en_c       = 1'b1;
                count_underrun = empty_tick;
            end
            default: begin
                dac_en_c       = 1'b0;
                count_underrun = 1'b0;
            end
        endcase
    end

    assign bus.dac_d        = dac_d_q;
    assign bus.dac_en       = dac_en_c;
    assign bus.dac_update   = dac_update_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.underrun     = underrun_q;
    assign bus.underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_rvmyth_dac_sample_sched.sv
// Bench for the DAC sample scheduler: directed scenarios plus randomized traffic, all
// compared every cycle against a tick-schedule/queue-style reference model.
module tb_rvmyth_dac_sample_sched;

    localparam int WIDTH       = 10;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic clk;
    logic reset;

    int checks;
    int failures;

    rvmyth_dac_sample_sched_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

    rvmyth_dac_sample_sched #(
        .WIDTH(WIDTH),
        .DIV_W(DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ticks are absolute cycle numbers, state is a plain 0/1/2 code.
    int step;
    int next_tick;
    int m_div;
    int m_state;
    int m_ptr;
    int m_d;
    int m_gid;
    int m_upd;
    int m_und;
    int m_cnt;
    int w;
    bit tick;

    initial begin
        step      = 0;
        next_tick = -1;
        m_div     = DEFAULT_DIV;
        m_state   = 0;
        m_ptr     = 0;
        m_d       = 0;
        m_gid     = 0;
        m_upd     = 0;
        m_und     = 0;
        m_cnt     = 0;
    end

    always @(negedge clk) begin
        step++;
        if (!reset) begin
            m_state   = 0;
            m_ptr     = 0;
            m_d       = 0;
            m_gid     = 0;
            m_upd     = 0;
            m_und     = 0;
            m_cnt     = 0;
            m_div     = DEFAULT_DIV;
            next_tick = step + 1 + DEFAULT_DIV;
            w         = -1;
            tick      = 1'b0;
        end else begin
            tick = (step == next_tick) && !bus.div_load;
            w    = -1;
            if (tick) begin
                if (bus.req0_valid && bus.req1_valid) w = m_ptr;
                else if (bus.req0_valid)              w = 0;
                else if (bus.req1_valid)              w = 1;
            end
        end

        check_output("req0_ready",   int'(bus.req0_ready),   int'(w == 0));
        check_output("req1_ready",   int'(bus.req1_ready),   int'(w == 1));
        check_output("dac_d",        int'(bus.dac_d),        m_d);
        check_output("dac_en",       int'(bus.dac_en),       int'(m_state != 0));
        check_output("dac_update",   int'(bus.dac_update),   m_upd);
        check_output("grant_id",     int'(bus.grant_id),     m_gid);
        check_output("underrun",     int'(bus.underrun),     m_und);
        check_output("underrun_cnt", int'(bus.underrun_cnt), m_cnt);

        if (reset) begin
            m_upd = 0;
            m_und = 0;
            if (w >= 0) begin
                m_d     = (w == 1) ? int'(bus.req1_data) : int'(bus.req0_data);
                m_gid   = w;
                m_upd   = 1;
                m_ptr   = (w == 0) ? 1 : 0;
                m_state = 1;
            end else if (tick && m_state != 0) begin
                m_und   = 1;
                m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_state = 2;
            end
            if (bus.div_load) begin
                m_div     = int'(bus.div_cfg);
                next_tick = step + 1 + m_div;
            end else if (tick) begin
                next_tick = step + 1 + m_div;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit v0, input int d0, input bit v1, input int d1);
        bus.req0_valid = v0;
        bus.req0_data  = WIDTH'(d0);
        bus.req1_valid = v1;
        bus.req1_data  = WIDTH'(d1);
    endtask

    // which: 0 = req0, 1 = req1, 2 = either; returns cycles waited before the ready cycle.
    task automatic wait_ready(input int which, input int budget, output bit got, output int waited);
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if ((which != 1 && bus.req0_ready) || (which != 0 && bus.req1_ready)) begin
                got    = 1'b1;
                waited = i;
                return;
            end
            wait_clk(1);
        end
        check_output("ready_timeout", 0, 1);
    endtask

    task automatic do_reset();
        wait_clk(1);
        reset = 1'b0;
        wait_clk(2);
        reset = 1'b1;
    endtask

    initial begin
        bit got;
        int n;
        int cnt_seen;

        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.div_cfg    = '0;
        bus.div_load   = 1'b0;
        apply_stimulus(0, 0, 0, 0);

        wait_clk(3);
        reset = 1'b1;

        // Idle after reset: nothing is granted and nothing is flagged.
        cnt_seen = 0;
        for (int i = 0; i < 20; i++) begin
            wait_clk(1);
            #1;
            if (bus.req0_ready || bus.req1_ready || bus.underrun) cnt_seen++;
        end
        check_output("idle_activity", cnt_seen, 0);
        check_output("idle_dac_en", int'(bus.dac_en), 0);
        check_output("idle_dac_d", int'(bus.dac_d), 0);

        // Single requester at the default rate.
        apply_stimulus(1, 'h155, 0, 0);
        wait_ready(0, 12, got, n);
        wait_clk(1);
        check_output("t2_dac_d", int'(bus.dac_d), 'h155);
        check_output("t2_update", int'(bus.dac_update), 1);
        check_output("t2_dac_en", int'(bus.dac_en), 1);
        check_output("t2_grant", int'(bus.grant_id), 0);
        wait_ready(0, 12, got, n);
        check_output("t2_period_gap", n, 4);

        // Both requesting: alternation starting with req0 after reset.
        apply_stimulus(0, 0, 0, 0);
        do_reset();
        apply_stimulus(1, 'h3FF, 1, 'h001);
        for (int k = 0; k < 4; k++) begin
            wait_ready(2, 12, got, n);
            check_output("t3_rr_grant", int'(bus.req1_ready), k % 2);
            wait_clk(1);
            check_output("t3_dac_d", int'(bus.dac_d), (k % 2) ? 'h001 : 'h3FF);
        end

        // Starvation for three ticks, then recovery from req1.
        apply_stimulus(0, 0, 0, 0);
        cnt_seen = 0;
        for (int i = 0; i < 15; i++) begin
            wait_clk(1);
            if (bus.underrun) cnt_seen++;
        end
        check_output("t4_underrun_pulses", cnt_seen, 3);
        check_output("t4_underrun_cnt", int'(bus.underrun_cnt), 3);
        check_output("t4_dac_d_held", int'(bus.dac_d), 'h001);
        apply_stimulus(0, 0, 1, 'h200);
        wait_ready(1, 10, got, n);
        wait_clk(1);
        check_output("t4_recover_d", int'(bus.dac_d), 'h200);
        check_output("t4_recover_grant", int'(bus.grant_id), 1);
        check_output("t4_recover_update", int'(bus.dac_update), 1);

        // Divider reload landing on a tick, then period 1 and period 3.
        apply_stimulus(1, $urandom_range(0, 1023), 0, 0);
        wait_ready(0, 10, got, n);
        bus.div_cfg  = 8'd0;
        bus.div_load = 1'b1;
        #1;
        check_output("t5_load_beats_tick", int'(bus.req0_ready), 0);
        wait_clk(1);
        bus.div_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output("t5_tick_every_clk", int'(bus.req0_ready), 1);
            wait_clk(1);
        end
        bus.div_cfg  = 8'd2;
        bus.div_load = 1'b1;
        wait_clk(1);
        bus.div_load = 1'b0;
        cnt_seen = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (bus.req0_ready) cnt_seen++;
            wait_clk(1);
        end
        check_output("t5_period3_ticks", cnt_seen, 3);

        // Asynchronous reset between edges, then saturation of the underrun counter.
        wait_clk(1);
        #2;
        reset = 1'b0;
        #1;
        check_output("t6_async_dac_en", int'(bus.dac_en), 0);
        check_output("t6_async_dac_d", int'(bus.dac_d), 0);
        check_output("t6_async_cnt", int'(bus.underrun_cnt), 0);
        check_output("t6_async_ready", int'(bus.req0_ready), 0);
        wait_clk(2);
        reset = 1'b1;
        apply_stimulus(1, 'h0AA, 0, 0);
        wait_ready(0, 10, got, n);
        wait_clk(1);
        apply_stimulus(0, 0, 0, 0);
        bus.div_cfg  = 8'd0;
        bus.div_load = 1'b1;
        wait_clk(1);
        bus.div_load = 1'b0;
        wait_clk(300);
        check_output("t6_sat_cnt", int'(bus.underrun_cnt), 255);
        check_output("t6_sat_pulse", int'(bus.underrun), 1);
        check_output("t6_sat_dac_d", int'(bus.dac_d), 'h0AA);
        check_output("t6_sat_dac_en", int'(bus.dac_en), 1);

        // Randomized traffic, divider reloads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            wait_clk(1);
            reset = ($urandom_range(0, 399) != 0);
            apply_stimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1023),
                           $urandom_range(0, 9) < 6, $urandom_range(0, 1023));
            bus.div_load = ($urandom_range(0, 15) == 0);
            bus.div_cfg  = DIV_W'($urandom_range(0, 6));
        end
        wait_clk(1);
        reset        = 1'b1;
        bus.div_load = 1'b0;
        apply_stimulus(0, 0, 0, 0);
        wait_clk(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
